// File: rtl/chirp_pkg.sv
// Shared definitions for the chirp responder: default widths, holdoff length and FSM state encoding.
package chirp_pkg;

  localparam int unsigned CHIRP_W       = 32;
  localparam int unsigned CHIRP_HOLDOFF = 16;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetup   = 3'd1,
    StRun     = 3'd2,
    StDone    = 3'd3,
    StHoldoff = 3'd4
  } chirp_state_e;

endpackage

// File: rtl/chirp_phase_ramp.sv
// Linear-FM phase-increment ramp for the DDS plus the fractional chirp-length accumulator.
module chirp_phase_ramp
  import chirp_pkg::*;
#(
  parameter int unsigned W = CHIRP_W
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] freq_start,
  input  logic [W-1:0] tuning,
  input  logic [W-1:0] frac,
  output logic [W-1:0] phase_inc,
  output logic         frac_carry
);

  logic [W-1:0] phase_q;
  logic [W-1:0] tuning_q;
  logic [W-1:0] acc_q;
  logic [W:0]   acc_sum;

  assign acc_sum    = {1'b0, acc_q} + {1'b0, frac};
  assign frac_carry = acc_sum[W];
  assign phase_inc  = phase_q;

  // The accumulator is never cleared between chirps so lengths average to int + frac/2^W.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase_q  <= '0;
      tuning_q <= '0;
      acc_q    <= '0;
    end else if (load) begin
      phase_q  <= freq_start;
      tuning_q <= tuning;
      acc_q    <= acc_sum[W-1:0];
    end else if (step) begin
      phase_q <= phase_q + tuning_q;
    end
  end

endmodule

// File: rtl/chirp_pulse_responder.sv
// Responder side of the radar chirp handshake: times each chirp to int+frac cycles and drives
// the DDS frequency ramp while reporting ready/active/done/aborted status to the pulse controller.
module chirp_pulse_responder
  import chirp_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = CHIRP_HOLDOFF,
  parameter int unsigned W              = CHIRP_W
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         dac_ready_in,
  input  logic [W-1:0] chirp_time_int,
  input  logic [W-1:0] chirp_time_frac,
  input  logic [W-1:0] chirp_freq_start,
  input  logic [W-1:0] chirp_tuning,
  input  logic         chirp_init,
  input  logic         chirp_enable,
  output logic         chirp_ready,
  output logic         chirp_active,
  output logic         chirp_done,
  output logic [W-1:0] dds_phase_inc,
  output logic         dds_valid,
  output logic         chirp_aborted,
  output logic [W-1:0] chirp_seq
);

  localparam int unsigned HoldW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  chirp_state_e   state_q;
  logic [W:0]     len_q;
  logic [HoldW-1:0] hold_q;
  logic           aborted_q;
  logic [W-1:0]   seq_q;

  logic           frac_carry;
  logic [W-1:0]   int_eff;
  logic [W:0]     len_base;
  logic           run_abort;
  logic           run_last;
  logic           ramp_load;
  logic           ramp_step;

  assign int_eff   = (chirp_time_int == '0) ? {{(W-1){1'b0}}, 1'b1} : chirp_time_int;
  // One extra bit so int = 2^W-1 plus a fractional carry cannot wrap.
  assign len_base  = {1'b0, int_eff} + {{W{1'b0}}, frac_carry};
  assign run_abort = (state_q == StRun) && (!chirp_enable || !dac_ready_in);
  assign run_last  = (len_q == {{W{1'b0}}, 1'b1});
  assign ramp_load = (state_q == StSetup);
  assign ramp_step = (state_q == StRun) && !run_abort && !run_last;

  assign chirp_ready   = (state_q == StIdle) && dac_ready_in;
  assign chirp_active  = (state_q == StRun);
  assign chirp_done    = (state_q == StDone);
  assign dds_valid     = chirp_active;
  assign chirp_aborted = aborted_q;
  assign chirp_seq     = seq_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      len_q     <= '0;
      hold_q    <= '0;
      aborted_q <= 1'b0;
      seq_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (chirp_init && chirp_ready) state_q <= StSetup;
        end
        StSetup: begin
          len_q     <= len_base;
          aborted_q <= 1'b0;
          state_q   <= StRun;
        end
        StRun: begin
          // Abort wins over normal completion so the sticky flag is still raised.
          if (run_abort) begin
            aborted_q <= 1'b1;
            state_q   <= StDone;
          end else if (run_last) begin
            state_q <= StDone;
          end else begin
            len_q <= len_q - {{W{1'b0}}, 1'b1};
          end
        end
        StDone: begin
          seq_q   <= seq_q + {{(W-1){1'b0}}, 1'b1};
          hold_q  <= HoldW'(HOLDOFF_CYCLES - 1);
          state_q <= StHoldoff;
        end
        StHoldoff: begin
          if (hold_q == '0) state_q <= StIdle;
          else              hold_q  <= hold_q - {{(HoldW-1){1'b0}}, 1'b1};
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  chirp_phase_ramp #(
    .W (W)
  ) u_ramp (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .load       (ramp_load),
    .step       (ramp_step),
    .freq_start (chirp_freq_start),
    .tuning     (chirp_tuning),
    .frac       (chirp_time_frac),
    .phase_inc  (dds_phase_inc),
    .frac_carry (frac_carry)
  );

endmodule

// File: tb/tb_chirp_pulse_responder.sv
// Directed self-checking bench for chirp_pulse_responder: timing, fractional lengths, ramp,
// abort, ignored inits, mid-chirp reset and sequence-counter wrap.
module tb_chirp_pulse_responder;

  localparam int unsigned HOLD = 16;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        dac_ready_in;
  logic [31:0] chirp_time_int;
  logic [31:0] chirp_time_frac;
  logic [31:0] chirp_freq_start;
  logic [31:0] chirp_tuning;
  logic        chirp_init;
  logic        chirp_enable;
  logic        chirp_ready;
  logic        chirp_active;
  logic        chirp_done;
  logic [31:0] dds_phase_inc;
  logic        dds_valid;
  logic        chirp_aborted;
  logic [31:0] chirp_seq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_seq = 32'd0;

  always #5 aclk = ~aclk;

  chirp_pulse_responder #(
    .HOLDOFF_CYCLES (HOLD),
    .W              (32)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .dac_ready_in     (dac_ready_in),
    .chirp_time_int   (chirp_time_int),
    .chirp_time_frac  (chirp_time_frac),
    .chirp_freq_start (chirp_freq_start),
    .chirp_tuning     (chirp_tuning),
    .chirp_init       (chirp_init),
    .chirp_enable     (chirp_enable),
    .chirp_ready      (chirp_ready),
    .chirp_active     (chirp_active),
    .chirp_done       (chirp_done),
    .dds_phase_inc    (dds_phase_inc),
    .dds_valid        (dds_valid),
    .chirp_aborted    (chirp_aborted),
    .chirp_seq        (chirp_seq)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (chirp_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (chirp_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", chirp_ready, n);
    end
  endtask

  // Starts one chirp and returns after the cycle in which done is seen (or a bound expires).
  task automatic run_chirp(input logic [31:0] ti, input logic [31:0] tf, output int act,
                           output int dones);
    chirp_time_int  = ti;
    chirp_time_frac = tf;
    chirp_enable    = 1'b1;
    wait_ready();
    chirp_init = 1'b1;
    tick();
    chirp_init = 1'b0;
    act   = 0;
    dones = 0;
    for (int i = 0; i < 300 && dones == 0; i++) begin
      tick();
      if (chirp_active === 1'b1) act++;
      if (chirp_done === 1'b1) dones++;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; dac_ready_in = 1'b0; chirp_init = 1'b0; chirp_enable = 1'b0;
    chirp_time_int = 32'd0; chirp_time_frac = 32'd0;
    chirp_freq_start = 32'd0; chirp_tuning = 32'd0;
    repeat (3) tick();
    checks++;
    if ({chirp_ready, chirp_active, chirp_done, dds_valid, chirp_aborted} !== 5'b0 ||
        dds_phase_inc !== 32'd0 || chirp_seq !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b act=%b done=%b val=%b abt=%b inc=%h seq=%h, required all 0",
               chirp_ready, chirp_active, chirp_done, dds_valid, chirp_aborted, dds_phase_inc,
               chirp_seq);
    end
    aresetn = 1'b1;
    dac_ready_in = 1'b1;
    tick();
    checks++;
    if (chirp_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: ready=%b, required 1", chirp_ready);
    end
  endtask

  task automatic test_basic();
    int act = 0;
    int hold = 0;
    chirp_time_int = 32'd10; chirp_time_frac = 32'd0; chirp_enable = 1'b1;
    wait_ready();
    chirp_init = 1'b1;
    tick();  // edge k: init accepted, SETUP cycle
    chirp_init = 1'b0;
    checks++;
    if (chirp_active !== 1'b0 || chirp_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_setup: act=%b rdy=%b, required 0 0", chirp_active, chirp_ready);
    end
    tick();  // first RUN cycle, seen by the controller at edge k+2
    checks++;
    if (chirp_active !== 1'b1) begin
      errors++; $display("FAIL basic_first_active: act=%b, required 1", chirp_active);
    end
    while (chirp_active === 1'b1 && act < 100) begin
      act++;
      tick();
    end
    checks++;
    if (act != 10) begin
      errors++; $display("FAIL basic_length: active cycles=%0d, required 10", act);
    end
    checks++;
    if (chirp_done !== 1'b1) begin
      errors++; $display("FAIL basic_done: done=%b, required 1", chirp_done);
    end
    exp_seq++;
    tick();
    checks++;
    if (chirp_done !== 1'b0 || chirp_seq !== exp_seq) begin
      errors++;
      $display("FAIL basic_done_pulse_seq: done=%b seq=%0d, required 0 %0d", chirp_done, chirp_seq,
               exp_seq);
    end
    while (chirp_ready !== 1'b1 && hold < 100) begin
      hold++;
      tick();
    end
    checks++;
    if (hold != HOLD) begin
      errors++; $display("FAIL basic_holdoff: ready-low cycles=%0d, required %0d", hold, HOLD);
    end
  endtask

  task automatic test_frac_back_to_back();
    int exp_len [4] = '{4, 5, 4, 5};
    int act, dones;
    for (int c = 0; c < 4; c++) begin
      run_chirp(32'd4, 32'h8000_0000, act, dones);
      exp_seq++;
      checks++;
      if (act != exp_len[c] || dones != 1) begin
        errors++;
        $display("FAIL frac_len_%0d: active=%0d dones=%0d, required %0d 1", c, act, dones,
                 exp_len[c]);
      end
    end
    checks++;
    if (dut.u_ramp.acc_q !== 32'd0) begin
      errors++; $display("FAIL frac_acc_end: acc=%h, required 0", dut.u_ramp.acc_q);
    end
  endtask

  task automatic test_ramp();
    logic [31:0] exp_inc [3] = '{32'h100, 32'h110, 32'h120};
    chirp_freq_start = 32'h100; chirp_tuning = 32'h10;
    chirp_time_int = 32'd3; chirp_time_frac = 32'd0; chirp_enable = 1'b1;
    wait_ready();
    chirp_init = 1'b1;
    tick();
    chirp_init = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dds_valid !== 1'b1 || dds_phase_inc !== exp_inc[i]) begin
        errors++;
        $display("FAIL ramp_step_%0d: valid=%b inc=%h, required 1 %h", i, dds_valid,
                 dds_phase_inc, exp_inc[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dds_valid !== 1'b0 || dds_phase_inc !== 32'h120) begin
        errors++;
        $display("FAIL ramp_hold_%0d: valid=%b inc=%h, required 0 120", i, dds_valid,
                 dds_phase_inc);
      end
    end
    exp_seq++;
    chirp_freq_start = 32'd0; chirp_tuning = 32'd0;
  endtask

  task automatic test_abort();
    int act = 0;
    int dones = 0;
    chirp_time_int = 32'd20; chirp_time_frac = 32'd0; chirp_enable = 1'b1;
    wait_ready();
    chirp_init = 1'b1;
    tick();
    chirp_init = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (chirp_active === 1'b1) act++;
    end
    chirp_enable = 1'b0;  // low during RUN cycle 5
    tick();
    exp_seq++;
    checks++;
    if (act != 5 || chirp_active !== 1'b0 || chirp_done !== 1'b1 || chirp_aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_enable: act_cycles=%0d act=%b done=%b abt=%b, required 5 0 1 1", act,
               chirp_active, chirp_done, chirp_aborted);
    end
    tick();
    checks++;
    if (chirp_done !== 1'b0 || chirp_aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_single_done: done=%b abt=%b, required 0 1", chirp_done, chirp_aborted);
    end
    chirp_enable = 1'b1;
    wait_ready();
    checks++;
    if (chirp_aborted !== 1'b1) begin
      errors++; $display("FAIL abort_sticky: abt=%b, required 1", chirp_aborted);
    end
    chirp_init = 1'b1;
    tick();
    chirp_init = 1'b0;
    tick();
    checks++;
    if (chirp_aborted !== 1'b0 || chirp_active !== 1'b1) begin
      errors++;
      $display("FAIL abort_clear: abt=%b act=%b, required 0 1", chirp_aborted, chirp_active);
    end
    for (int i = 0; i < 40 && dones == 0; i++) begin
      tick();
      if (chirp_done === 1'b1) dones++;
    end
    exp_seq++;
    checks++;
    if (dones != 1 || chirp_aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_normal_after: dones=%0d abt=%b, required 1 0", dones, chirp_aborted);
    end
    // 1-cycle chirp killed by dac_ready on its first and last cycle: abort must still register.
    chirp_time_int = 32'd1;
    wait_ready();
    chirp_init = 1'b1;
    tick();
    chirp_init = 1'b0;
    tick();
    dac_ready_in = 1'b0;
    tick();
    exp_seq++;
    checks++;
    if (chirp_done !== 1'b1 || chirp_aborted !== 1'b1 || chirp_active !== 1'b0) begin
      errors++;
      $display("FAIL abort_dac_priority: done=%b abt=%b act=%b, required 1 1 0", chirp_done,
               chirp_aborted, chirp_active);
    end
    dac_ready_in = 1'b1;
  endtask

  task automatic test_ignored_init();
    int act = 0;
    int dones = 0;
    wait_ready();
    dac_ready_in = 1'b0;
    tick();
    checks++;
    if (chirp_ready !== 1'b0) begin
      errors++; $display("FAIL dac_low_ready: ready=%b, required 0", chirp_ready);
    end
    chirp_time_int = 32'd3; chirp_enable = 1'b1; chirp_init = 1'b1;
    tick();
    chirp_init = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (chirp_active === 1'b1) act++;
    end
    checks++;
    if (act != 0 || chirp_seq !== exp_seq) begin
      errors++;
      $display("FAIL dac_low_init_ignored: act_cycles=%0d seq=%0d, required 0 %0d", act,
               chirp_seq, exp_seq);
    end
    dac_ready_in = 1'b1;
    tick();
    checks++;
    if (chirp_ready !== 1'b1) begin
      errors++; $display("FAIL dac_high_ready: ready=%b, required 1", chirp_ready);
    end
    // Extra inits land in RUN cycle 3 and mid-HOLDOFF.
    chirp_time_int = 32'd6;
    chirp_init = 1'b1;
    tick();
    chirp_init = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (chirp_active === 1'b1) act++;
      if (chirp_done === 1'b1) dones++;
      chirp_init = (i == 2 || i == 10);
    end
    exp_seq++;
    checks++;
    if (act != 6 || dones != 1 || chirp_seq !== exp_seq || chirp_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_init_ignored: act=%0d dones=%0d seq=%0d rdy=%b, required 6 1 %0d 1",
               act, dones, chirp_seq, chirp_ready, exp_seq);
    end
    run_chirp(32'd0, 32'd0, act, dones);
    exp_seq++;
    checks++;
    if (act != 1 || dones != 1) begin
      errors++;
      $display("FAIL int_zero: active=%0d dones=%0d, required 1 1", act, dones);
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    int act, dones;
    chirp_time_int = 32'd10; chirp_time_frac = 32'd0; chirp_enable = 1'b1;
    chirp_freq_start = 32'h55; chirp_tuning = 32'h1;
    wait_ready();
    chirp_init = 1'b1;
    tick();
    chirp_init = 1'b0;
    repeat (3) tick();  // RUN cycle 3
    aresetn = 1'b0;
    tick();
    checks++;
    if ({chirp_active, chirp_done, dds_valid, chirp_aborted} !== 4'b0 ||
        dds_phase_inc !== 32'd0 || chirp_seq !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_run: act=%b done=%b val=%b abt=%b inc=%h seq=%h, required all 0",
               chirp_active, chirp_done, dds_valid, chirp_aborted, dds_phase_inc, chirp_seq);
    end
    aresetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (chirp_done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || chirp_seq !== 32'd0 || chirp_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_done: dones=%0d seq=%0d rdy=%b, required 0 0 1", dones, chirp_seq,
               chirp_ready);
    end
    chirp_freq_start = 32'd0; chirp_tuning = 32'd0;
    force dut.seq_q = 32'hFFFF_FFFF;
    tick();
    release dut.seq_q;
    tick();
    checks++;
    if (chirp_seq !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL seq_preset: seq=%h, required ffffffff", chirp_seq);
    end
    run_chirp(32'd2, 32'd0, act, dones);
    tick();
    checks++;
    if (dones != 1 || chirp_seq !== 32'd0) begin
      errors++;
      $display("FAIL seq_wrap: dones=%0d seq=%h, required 1 00000000", dones, chirp_seq);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac_back_to_back();
    test_ramp();
    test_abort();
    test_ignored_init();
    test_reset_mid_and_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
